// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline constants: MULDIV funct encodings, ALUOp code and the
// EX-stage multiply unit state type.
package riscv_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } ex_mul_state_t;

endpackage

// File: rtl/ex_mul_unit.sv
// Iterative RV32M multiply unit for the EX stage: 32 shift-add iterations on
// operand magnitudes, sign fix-up on the way into DONE, stall while working.
module ex_mul_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [9:0]      funct_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            RegWrite_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o,
  output logic            RegWrite_o
);

  ex_mul_state_t state_q, state_d;

  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic [2:0]        f3_q, f3_d;
  logic [4:0]        rd_q, rd_d;
  logic              rw_q, rw_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;
  logic              rw_out_q, rw_out_d;

  logic              is_mul;
  logic              s1, s2;
  logic [2*XLEN-1:0] fin;

  always_comb begin
    is_mul = (funct_i[9:3] == FUNCT7_MULDIV) && !funct_i[2];
    // Only signed operands contribute a sign; MUL is treated as unsigned since
    // the low half of the product does not depend on signedness.
    s1 = rs1_data_i[XLEN-1] &&
         ((funct_i[2:0] == F3_MULH) || (funct_i[2:0] == F3_MULHSU));
    s2 = rs2_data_i[XLEN-1] && (funct_i[2:0] == F3_MULH);
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    f3_d     = f3_q;
    rd_d     = rd_q;
    rw_d     = rw_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    rw_out_d = rw_out_q;
    fin      = '0;

    unique case (state_q)
      IDLE: begin
        if (start_i && is_mul) begin
          mcand_d  = s1 ? -rs1_data_i : rs1_data_i;
          mplier_d = s2 ? -rs2_data_i : rs2_data_i;
          neg_d    = s1 ^ s2;
          f3_d     = funct_i[2:0];
          rd_d     = rd_addr_i;
          rw_d     = RegWrite_i;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + ({{XLEN{1'b0}}, mcand_q} << cnt_q);
        end
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        // Result is registered on the last iteration so it is already valid
        // in the DONE cycle alongside the done pulse.
        if (cnt_q == '1) begin
          fin      = neg_q ? -acc_d : acc_d;
          result_d = (f3_q == F3_MUL) ? fin[XLEN-1:0] : fin[2*XLEN-1:XLEN];
          rd_out_d = rd_q;
          rw_out_d = rw_q;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      f3_q     <= '0;
      rd_q     <= '0;
      rw_q     <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
      rw_out_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      f3_q     <= f3_d;
      rd_q     <= rd_d;
      rw_q     <= rw_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
      rw_out_q <= rw_out_d;
    end
  end

  assign stall_o    = ((state_q == IDLE) && start_i && is_mul) || (state_q == BUSY);
  assign done_o     = (state_q == DONE);
  assign result_o   = result_q;
  assign rd_addr_o  = rd_out_q;
  assign RegWrite_o = rw_out_q;

endmodule

// File: tb/tb_ex_mul_unit.sv
// Directed bench for ex_mul_unit: vector table of multiplies plus hand-written
// sequences for non-multiply, mid-operation reset and back-to-back operation.
module tb_ex_mul_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [9:0]  funct;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd;
  logic        rw;
  logic        stall, done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        rw_out;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  ex_mul_unit #(.XLEN(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .funct_i    (funct),
    .rs1_data_i (rs1),
    .rs2_data_i (rs2),
    .rd_addr_i  (rd),
    .RegWrite_i (rw),
    .stall_o    (stall),
    .done_o     (done),
    .result_o   (result),
    .rd_addr_o  (rd_out),
    .RegWrite_o (rw_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [9:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] exp;
  } vec_t;

  localparam logic [9:0] FN_MUL    = 10'b0000001_000;
  localparam logic [9:0] FN_MULH   = 10'b0000001_001;
  localparam logic [9:0] FN_MULHSU = 10'b0000001_010;
  localparam logic [9:0] FN_MULHU  = 10'b0000001_011;
  localparam logic [9:0] FN_ADD    = 10'b0000000_000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Issue one multiply in cycle T and observe cycles T+1..T+40.
  task automatic run_mul(input vec_t v);
    int unsigned stall_cnt, done_cnt, done_at;
    logic [31:0] res_at_done;
    logic [4:0]  rd_at_done;
    logic        rw_at_done;
    funct = v.funct; rs1 = v.a; rs2 = v.b; rd = v.rd; rw = v.rw; start = 1'b1;
    #1;
    stall_cnt = stall ? 1 : 0;
    done_cnt = 0; done_at = 0;
    res_at_done = '0; rd_at_done = '0; rw_at_done = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (stall) stall_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at = k; res_at_done = result; rd_at_done = rd_out; rw_at_done = rw_out;
        end
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({v.name, " done cycle"}, 64'(done_at), 64'd33);
    check({v.name, " done count"}, 64'(done_cnt), 64'd1);
    check({v.name, " stall cycles"}, 64'(stall_cnt), 64'd33);
    check({v.name, " result"}, {32'h0, res_at_done}, {32'h0, v.exp});
    check({v.name, " rd"}, {59'h0, rd_at_done}, {59'h0, v.rd});
    check({v.name, " regwrite"}, {63'h0, rw_at_done}, {63'h0, v.rw});
    check({v.name, " result held"}, {32'h0, result}, {32'h0, v.exp});
  endtask

  vec_t vecs[$];

  initial begin
    int unsigned stall_seen, done_seen, d1, d2;
    logic [31:0] r1, r2;

    vecs.push_back('{"mul_7x6",        FN_MUL,    32'd7,        32'd6,        5'd3,  1'b1, 32'h0000002A});
    vecs.push_back('{"mul_ffff_x2",    FN_MUL,    32'hFFFFFFFF, 32'h00000002, 5'd31, 1'b1, 32'hFFFFFFFE});
    vecs.push_back('{"mulh_m1_m1",     FN_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  1'b0, 32'h00000000});
    vecs.push_back('{"mulhu_max",      FN_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9,  1'b1, 32'hFFFFFFFE});
    vecs.push_back('{"mulhsu_m1_max",  FN_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 1'b1, 32'hFFFFFFFF});
    vecs.push_back('{"mulh_m2_x3",     FN_MULH,   32'hFFFFFFFE, 32'h00000003, 5'd1,  1'b1, 32'hFFFFFFFF});
    vecs.push_back('{"mulh_min_min",   FN_MULH,   32'h80000000, 32'h80000000, 5'd20, 1'b1, 32'h40000000});
    vecs.push_back('{"mulhu_2p31_x2",  FN_MULHU,  32'h80000000, 32'h00000002, 5'd5,  1'b1, 32'h00000001});
    vecs.push_back('{"mul_zero",       FN_MUL,    32'h00000000, 32'h12345678, 5'd4,  1'b1, 32'h00000000});

    rst = 1'b1; start = 1'b0; funct = '0; rs1 = '0; rs2 = '0; rd = '0; rw = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset stall", {63'h0, stall}, 64'h0);
    check("reset done", {63'h0, done}, 64'h0);
    check("reset result", {32'h0, result}, 64'h0);
    check("reset rd", {59'h0, rd_out}, 64'h0);
    check("reset regwrite", {63'h0, rw_out}, 64'h0);

    foreach (vecs[i]) run_mul(vecs[i]);

    // Non-multiply R-type: no stall, no done, result untouched.
    funct = FN_ADD; rs1 = 32'd1; rs2 = 32'd2; rd = 5'd6; rw = 1'b1; start = 1'b1;
    #1;
    stall_seen = stall ? 1 : 0; done_seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (stall) stall_seen++;
      if (done) done_seen++;
    end
    start = 1'b0;
    check("add stall", 64'(stall_seen), 64'd0);
    check("add done", 64'(done_seen), 64'd0);
    check("add result unchanged", {32'h0, result}, 64'h0);

    // MUL 3*5 aborted by reset during cycle T+10.
    funct = FN_MUL; rs1 = 32'd3; rs2 = 32'd5; rd = 5'd8; rw = 1'b1; start = 1'b1;
    for (int k = 1; k <= 10; k++) tick();
    check("abort stall before rst", {63'h0, stall}, 64'h1);
    rst = 1'b1; start = 1'b0;
    tick();
    rst = 1'b0;
    check("abort stall T+11", {63'h0, stall}, 64'h0);
    done_seen = 0; stall_seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) done_seen++;
      if (stall) stall_seen++;
      tick();
    end
    check("abort no done", 64'(done_seen), 64'd0);
    check("abort no stall", 64'(stall_seen), 64'd0);
    check("abort result", {32'h0, result}, 64'h0);
    check("abort rd", {59'h0, rd_out}, 64'h0);
    check("abort regwrite", {63'h0, rw_out}, 64'h0);
    run_mul('{"mul_2x2_after_abort", FN_MUL, 32'd2, 32'd2, 5'd10, 1'b1, 32'h00000004});

    // Back-to-back: start held through DONE; ID/EX advances after each DONE.
    funct = FN_MUL; rs1 = 32'd2; rs2 = 32'd3; rd = 5'd11; rw = 1'b1; start = 1'b1;
    #1;
    done_seen = 0; d1 = 0; d2 = 0; r1 = '0; r2 = '0;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (done) begin
        done_seen++;
        if (done_seen == 1) begin
          d1 = k; r1 = result; rs1 = 32'd4; rs2 = 32'd5;
        end else if (done_seen == 2) begin
          d2 = k; r2 = result; start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b done pulses", 64'(done_seen), 64'd2);
    check("b2b first done", 64'(d1), 64'd33);
    check("b2b second done", 64'(d2), 64'd67);
    check("b2b first result", {32'h0, r1}, 64'h6);
    check("b2b second result", {32'h0, r2}, 64'h14);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
